// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA channel arbiter.
//   NUM_CH            : number of DMA channels (4)
//   CH_W              : channel index width
//   CHANNEL_SELECT_e  : channel index type, used for grant_ch
//   arb_state_idx_e   : bit position of each arbiter state in the one-hot vector
//   arb_state_e       : one-hot arbiter state encoding
//   next_channel()    : channel that follows ch in the rotating order (3 wraps to 0)
package dma_priority_arbiter_pkg;

   localparam int unsigned NUM_CH      = 4;
   localparam int unsigned CH_W        = 2;
   localparam int unsigned ARB_STATE_W = 4;

   typedef enum logic [CH_W-1:0] {
      CH0 = 2'd0,
      CH1 = 2'd1,
      CH2 = 2'd2,
      CH3 = 2'd3
   } CHANNEL_SELECT_e;

   typedef enum int unsigned {
      iARB_IDLE    = 0,
      iARB_HOLD    = 1,
      iARB_GRANT   = 2,
      iARB_RELEASE = 3
   } arb_state_idx_e;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE    = 4'b0001 << iARB_IDLE,
      ARB_HOLD    = 4'b0001 << iARB_HOLD,
      ARB_GRANT   = 4'b0001 << iARB_GRANT,
      ARB_RELEASE = 4'b0001 << iARB_RELEASE
   } arb_state_e;

   // Rotation step: the channel after ch becomes highest priority.
   function automatic CHANNEL_SELECT_e next_channel(input CHANNEL_SELECT_e ch);
      logic [CH_W-1:0] nxt;
      nxt = CH_W'(ch + 2'd1);
      return CHANNEL_SELECT_e'(nxt);
   endfunction

endpackage

// File: rtl/dma_priority_arbiter_rotating_prio_enc.sv
// Combinational priority encoder with a movable top-priority channel.
//   vreq : conditioned channel requests
//   hp   : channel with highest priority; order is hp, hp+1, hp+2, hp+3 (mod 4)
//   win  : first requesting channel in that order (hp when nothing requests)
//   any  : at least one request present
module dma_rotating_prio_enc
   import dma_priority_arbiter_pkg::*;
(
   input  logic [NUM_CH-1:0] vreq,
   input  logic [CH_W-1:0]   hp,
   output logic [CH_W-1:0]   win,
   output logic              any
);

   // Walk the channels starting at hp; the first hit wins.
   always_comb begin
      logic            found;
      logic [CH_W-1:0] idx;
      win   = hp;
      any   = |vreq;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         idx = CH_W'(hp + CH_W'(k));
         if (!found && vreq[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Request resolver and bus-hold sequencer for four 8237A-style DMA channels.
//   CLK, RESET_N  : clock, synchronous active-low reset
//   DREQ          : hardware requests, active level chosen by dreq_pol
//   mask, swreq   : mask register (1 blocks DREQ) and software request bits
//   dreq_pol      : 0 DREQ active-high, 1 active-low
//   dack_pol      : 0 DACK active-low, 1 active-high
//   rot_pri       : 0 fixed priority (channel 0 highest), 1 rotating priority
//   ctrl_disable  : blocks new arbitration, never an ongoing grant
//   HLDA          : hold acknowledge from the CPU
//   eop           : end-of-service pulse from the timing FSM
//   HRQ           : hold request (registered)
//   DACK          : per-channel acknowledge, decoded from registered grant state
//   grant_valid   : a channel owns the bus (registered)
//   grant_ch      : serviced channel, holds its value after the grant ends
module dma_priority_arbiter #(
   parameter int unsigned NUM_CH = 4
) (
   input  logic                                     CLK,
   input  logic                                     RESET_N,
   input  logic [NUM_CH-1:0]                        DREQ,
   input  logic [NUM_CH-1:0]                        mask,
   input  logic [NUM_CH-1:0]                        swreq,
   input  logic                                     dreq_pol,
   input  logic                                     dack_pol,
   input  logic                                     rot_pri,
   input  logic                                     ctrl_disable,
   input  logic                                     HLDA,
   input  logic                                     eop,
   output logic                                     HRQ,
   output logic [NUM_CH-1:0]                        DACK,
   output logic                                     grant_valid,
   output dma_priority_arbiter_pkg::CHANNEL_SELECT_e grant_ch
);

   import dma_priority_arbiter_pkg::*;

   localparam logic [ARB_STATE_W-1:0] ST_IDLE    = ARB_IDLE;
   localparam logic [ARB_STATE_W-1:0] ST_HOLD    = ARB_HOLD;
   localparam logic [ARB_STATE_W-1:0] ST_GRANT   = ARB_GRANT;
   localparam logic [ARB_STATE_W-1:0] ST_RELEASE = ARB_RELEASE;

   logic [ARB_STATE_W-1:0] state_q, state_d;
   logic [CH_W-1:0]        hp_q, hp_d;
   CHANNEL_SELECT_e        grant_ch_q, grant_ch_d;
   logic                   hrq_q, hrq_d;
   logic                   grant_valid_q, grant_valid_d;

   logic [NUM_CH-1:0]      vreq_c;
   logic [CH_W-1:0]        win_c;
   logic                   req_any_c;
   logic [NUM_CH-1:0]      dack_c;

   // Software requests bypass both polarity and mask.
   assign vreq_c = ((DREQ ^ {NUM_CH{dreq_pol}}) & ~mask) | swreq;

   dma_rotating_prio_enc u_prio_enc (
      .vreq (vreq_c),
      .hp   (hp_q),
      .win  (win_c),
      .any  (req_any_c)
   );

   // Next state, priority pointer and grant latch.
   always_comb begin
      state_d    = state_q;
      hp_d       = rot_pri ? hp_q : '0;
      grant_ch_d = grant_ch_q;

      case (state_q)
         ST_IDLE: begin
            if (req_any_c && !ctrl_disable) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Winner is re-resolved every cycle until HLDA arrives.
            if (!req_any_c) begin
               state_d = ST_IDLE;
            end else if (HLDA) begin
               state_d    = ST_GRANT;
               grant_ch_d = CHANNEL_SELECT_e'(win_c);
            end
         end
         ST_GRANT: begin
            // eop takes precedence over a simultaneous HLDA drop.
            if (eop) begin
               state_d = ST_RELEASE;
               if (rot_pri) begin
                  hp_d = next_channel(grant_ch_q);
               end
            end else if (!HLDA) begin
               state_d = ST_IDLE;
            end
         end
         ST_RELEASE: begin
            if (!HLDA) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      hrq_d         = (state_d == ST_HOLD) || (state_d == ST_GRANT);
      grant_valid_d = (state_d == ST_GRANT);
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q       <= ST_IDLE;
         hp_q          <= '0;
         grant_ch_q    <= CH0;
         hrq_q         <= 1'b0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hp_q          <= hp_d;
         grant_ch_q    <= grant_ch_d;
         hrq_q         <= hrq_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   // DACK decode; the inactive level is ~dack_pol.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         dack_c[i] = (grant_valid_q && (grant_ch_q == CH_W'(i))) ~^ dack_pol;
      end
   end

   assign HRQ         = hrq_q;
   assign grant_valid = grant_valid_q;
   assign grant_ch    = grant_ch_q;
   assign DACK        = dack_c;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_dma_priority_arbiter;

   logic       CLK;
   logic       RESET_N;
   logic [3:0] DREQ, mask, swreq;
   logic       dreq_pol, dack_pol, rot_pri, ctrl_disable, HLDA, eop;
   logic       HRQ;
   logic [3:0] DACK;
   logic       grant_valid;
   logic [1:0] grant_ch;

   int checks = 0;
   int errors = 0;

   // Behavioural model: phase 0 idle, 1 hold, 2 grant, 3 release.
   int m_phase = 0;
   int m_hp    = 0;
   int m_gch   = 0;

   dma_priority_arbiter dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .DREQ         (DREQ),
      .mask         (mask),
      .swreq        (swreq),
      .dreq_pol     (dreq_pol),
      .dack_pol     (dack_pol),
      .rot_pri      (rot_pri),
      .ctrl_disable (ctrl_disable),
      .HLDA         (HLDA),
      .eop          (eop),
      .HRQ          (HRQ),
      .DACK         (DACK),
      .grant_valid  (grant_valid),
      .grant_ch     (grant_ch)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic int model_req(input int ch);
      bit hw;
      hw = ((DREQ[ch] ^ dreq_pol) == 1'b1) && (mask[ch] == 1'b0);
      return (hw || swreq[ch] == 1'b1) ? 1 : 0;
   endfunction

   function automatic int model_winner();
      for (int k = 0; k < 4; k++) begin
         if (model_req((m_hp + k) % 4) != 0) return (m_hp + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w, nhp;
      if (RESET_N !== 1'b1) begin
         m_phase = 0; m_hp = 0; m_gch = 0;
      end else begin
         w   = model_winner();
         nhp = (rot_pri === 1'b1) ? m_hp : 0;
         case (m_phase)
            0: if (w >= 0 && ctrl_disable !== 1'b1) m_phase = 1;
            1: if (w < 0) m_phase = 0;
               else if (HLDA === 1'b1) begin m_phase = 2; m_gch = w; end
            2: if (eop === 1'b1) begin
                  m_phase = 3;
                  if (rot_pri === 1'b1) nhp = (m_gch + 1) % 4;
               end else if (HLDA !== 1'b1) m_phase = 0;
            default: if (HLDA !== 1'b1) m_phase = 0;
         endcase
         m_hp = nhp;
      end
   endtask

   function automatic logic [3:0] model_dack();
      logic [3:0] d;
      for (int i = 0; i < 4; i++) begin
         d[i] = (m_phase == 2 && m_gch == i) ? dack_pol : ~dack_pol;
      end
      return d;
   endfunction

   // One clock: model and DUT see the same sampled inputs; outputs read 1 ns later.
   task automatic cyc();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      DREQ = 4'b0; mask = 4'b0; swreq = 4'b0;
      dreq_pol = 1'b0; dack_pol = 1'b0; rot_pri = 1'b0;
      ctrl_disable = 1'b0; HLDA = 1'b0; eop = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      RESET_N = 1'b0;
      cyc();
      RESET_N = 1'b1;
   endtask

   task automatic wait_hrq(output bit ok);
      int n = 0;
      while (HRQ !== 1'b1 && n < 20) begin cyc(); n++; end
      ok = (HRQ === 1'b1);
   endtask

   task automatic test_reset();
      idle_inputs();
      RESET_N = 1'b0;
      cyc(); cyc();
      checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL reset_hrq: got %b expected 0", HRQ); end
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b expected 0", grant_valid); end
      checks++; if (grant_ch !== 2'd0) begin errors++; $display("FAIL reset_gch: got %0d expected 0", grant_ch); end
      checks++; if (DACK !== 4'b1111) begin errors++; $display("FAIL reset_dack: got %b expected 1111", DACK); end
      checks++; if (dut.hp_q !== 2'd0) begin errors++; $display("FAIL reset_hp: got %0d expected 0", dut.hp_q); end
      RESET_N = 1'b1;
      cyc();
   endtask

   task automatic test_fixed_priority();
      apply_reset();
      DREQ = 4'b1010;
      cyc();
      checks++; if (HRQ !== 1'b1) begin errors++; $display("FAIL fixed_hrq: got %b expected 1", HRQ); end
      HLDA = 1'b1;
      cyc();
      checks++; if (grant_valid !== 1'b1 || grant_ch !== 2'd1) begin errors++; $display("FAIL fixed_grant: got gv=%b ch=%0d expected gv=1 ch=1", grant_valid, grant_ch); end
      checks++; if (DACK !== 4'b1101) begin errors++; $display("FAIL fixed_dack: got %b expected 1101", DACK); end
      eop = 1'b1;
      cyc();
      eop = 1'b0;
      checks++; if (HRQ !== 1'b0 || grant_valid !== 1'b0 || DACK !== 4'b1111) begin errors++; $display("FAIL fixed_release: got hrq=%b gv=%b dack=%b expected 0 0 1111", HRQ, grant_valid, DACK); end
      HLDA = 1'b0;
      cyc();
      checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL turnaround_early: got %b expected 0", HRQ); end
      cyc();
      checks++; if (HRQ !== 1'b1) begin errors++; $display("FAIL turnaround_hrq: got %b expected 1", HRQ); end
      DREQ = 4'b0;
      cyc();
   endtask

   task automatic test_rotation();
      bit ok;
      apply_reset();
      rot_pri = 1'b1;
      DREQ = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         wait_hrq(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rot_hrq_timeout: round %0d got hrq=%b expected 1", r, HRQ); end
         HLDA = 1'b1;
         cyc();
         checks++; if (grant_valid !== 1'b1 || grant_ch !== 2'(r)) begin errors++; $display("FAIL rot_grant: round %0d got ch=%0d gv=%b expected ch=%0d gv=1", r, grant_ch, grant_valid, r); end
         eop = 1'b1;
         cyc();
         eop = 1'b0; HLDA = 1'b0;
         checks++; if (dut.hp_q !== 2'((r + 1) % 4)) begin errors++; $display("FAIL rot_hp: round %0d got %0d expected %0d", r, dut.hp_q, (r + 1) % 4); end
         cyc();
      end
      DREQ = 4'b0;
      cyc(); cyc();
      // eop outside a grant must not rotate.
      eop = 1'b1;
      cyc();
      eop = 1'b0;
      checks++; if (dut.hp_q !== 2'd0 || HRQ !== 1'b0) begin errors++; $display("FAIL stray_eop: got hp=%0d hrq=%b expected hp=0 hrq=0", dut.hp_q, HRQ); end
      rot_pri = 1'b0;
      cyc();
   endtask

   task automatic test_mask_swreq();
      apply_reset();
      mask = 4'b1111; DREQ = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL masked_hrq: cycle %0d got %b expected 0", i, HRQ); end
      end
      swreq = 4'b0100;
      cyc();
      checks++; if (HRQ !== 1'b1) begin errors++; $display("FAIL swreq_hrq: got %b expected 1", HRQ); end
      HLDA = 1'b1;
      cyc();
      checks++; if (grant_ch !== 2'd2 || grant_valid !== 1'b1) begin errors++; $display("FAIL swreq_grant: got ch=%0d gv=%b expected ch=2 gv=1", grant_ch, grant_valid); end
      eop = 1'b1;
      cyc();
      eop = 1'b0; HLDA = 1'b0; swreq = 4'b0; mask = 4'b0; DREQ = 4'b0;
      cyc(); cyc();
   endtask

   task automatic test_withdraw_abort();
      apply_reset();
      rot_pri = 1'b1;
      DREQ = 4'b0001;
      cyc();
      DREQ = 4'b0000;
      cyc();
      checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL withdraw_hrq: got %b expected 0", HRQ); end
      DREQ = 4'b0100;
      cyc();
      HLDA = 1'b1;
      cyc();
      ctrl_disable = 1'b1; DREQ = 4'b0; mask = 4'b1111;
      cyc();
      checks++; if (grant_valid !== 1'b1 || grant_ch !== 2'd2 || HRQ !== 1'b1) begin errors++; $display("FAIL grant_sticky: got gv=%b ch=%0d hrq=%b expected 1 2 1", grant_valid, grant_ch, HRQ); end
      HLDA = 1'b0;
      cyc();
      checks++; if (grant_valid !== 1'b0 || HRQ !== 1'b0 || grant_ch !== 2'd2 || dut.hp_q !== 2'd0) begin errors++; $display("FAIL abort: got gv=%b hrq=%b ch=%0d hp=%0d expected 0 0 2 0", grant_valid, HRQ, grant_ch, dut.hp_q); end
      mask = 4'b0; DREQ = 4'b0001;
      cyc(); cyc();
      checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL disable_hrq: got %b expected 0", HRQ); end
      ctrl_disable = 1'b0; DREQ = 4'b1000;
      cyc();
      HLDA = 1'b1;
      cyc();
      eop = 1'b1; HLDA = 1'b0;
      cyc();
      eop = 1'b0; DREQ = 4'b0;
      checks++; if (grant_valid !== 1'b0 || HRQ !== 1'b0 || dut.hp_q !== 2'd0 || grant_ch !== 2'd3) begin errors++; $display("FAIL eop_beats_drop: got gv=%b hrq=%b hp=%0d ch=%0d expected 0 0 0 3", grant_valid, HRQ, dut.hp_q, grant_ch); end
      cyc(); cyc();
      rot_pri = 1'b0;
   endtask

   task automatic test_polarity();
      apply_reset();
      dreq_pol = 1'b1; DREQ = 4'b1110;
      cyc();
      checks++; if (HRQ !== 1'b1) begin errors++; $display("FAIL pol_hrq: got %b expected 1", HRQ); end
      HLDA = 1'b1; dack_pol = 1'b1;
      cyc();
      checks++; if (grant_ch !== 2'd0 || DACK !== 4'b0001) begin errors++; $display("FAIL pol_grant: got ch=%0d dack=%b expected ch=0 dack=0001", grant_ch, DACK); end
      eop = 1'b1;
      cyc();
      eop = 1'b0; HLDA = 1'b0;
      checks++; if (DACK !== 4'b0000) begin errors++; $display("FAIL pol_dack_idle: got %b expected 0000", DACK); end
      DREQ = 4'b1111;
      cyc(); cyc();
      checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL pol_inactive: got %b expected 0", HRQ); end
      idle_inputs();
      cyc();
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      rot_pri = 1'b1; DREQ = 4'b0010;
      cyc();
      HLDA = 1'b1;
      cyc();
      checks++; if (grant_valid !== 1'b1 || grant_ch !== 2'd1) begin errors++; $display("FAIL rmg_grant: got gv=%b ch=%0d expected 1 1", grant_valid, grant_ch); end
      RESET_N = 1'b0; eop = 1'b1;
      cyc();
      RESET_N = 1'b1; eop = 1'b0;
      checks++; if (HRQ !== 1'b0 || grant_valid !== 1'b0 || dut.hp_q !== 2'd0 || grant_ch !== 2'd0 || DACK !== 4'b1111) begin errors++; $display("FAIL rmg_reset: got hrq=%b gv=%b hp=%0d ch=%0d dack=%b expected 0 0 0 0 1111", HRQ, grant_valid, dut.hp_q, grant_ch, DACK); end
      idle_inputs();
      cyc();
   endtask

   task automatic test_random();
      logic [3:0] ed;
      apply_reset();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(3) == 0) DREQ = 4'($urandom);
         if ($urandom_range(15) == 0) mask = 4'($urandom);
         swreq        = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
         if ($urandom_range(31) == 0) dreq_pol = ~dreq_pol;
         dack_pol     = 1'($urandom);
         rot_pri      = ($urandom_range(9) != 0);
         ctrl_disable = ($urandom_range(7) == 0);
         if ($urandom_range(2) == 0) HLDA = ~HLDA;
         eop          = ($urandom_range(3) == 0);
         RESET_N      = ($urandom_range(199) != 0);
         cyc();
         ed = model_dack();
         checks++;
         if (HRQ !== (m_phase == 1 || m_phase == 2) || grant_valid !== (m_phase == 2) ||
             grant_ch !== 2'(m_gch) || DACK !== ed || dut.hp_q !== 2'(m_hp)) begin
            errors++;
            $display("FAIL random: cycle %0d got hrq=%b gv=%b ch=%0d dack=%b hp=%0d expected hrq=%0d gv=%0d ch=%0d dack=%b hp=%0d",
                     n, HRQ, grant_valid, grant_ch, DACK, dut.hp_q,
                     (m_phase == 1 || m_phase == 2), (m_phase == 2), m_gch, ed, m_hp);
         end
      end
      RESET_N = 1'b1;
      idle_inputs();
      cyc();
   endtask

   initial begin
      RESET_N = 1'b0;
      idle_inputs();
      test_reset();
      test_fixed_priority();
      test_rotation();
      test_mask_swreq();
      test_withdraw_abort();
      test_polarity();
      test_reset_mid_grant();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Request resolver and bus-hold sequencer for the four 8237A-style DMA channels. Conditions DREQ inputs (polarity, mask, software request, controller enable), picks one channel under fixed or rotating priority, runs the HRQ/HLDA hold handshake with the CPU, and drives the DACK outputs for the serviced channel. Sits between the command/mask/request registers and the S0–S4 timing FSM, which reports end of service on `eop`.

## Interface
Parameters:
- `NUM_CH`, default 4: number of channels; only 4 is supported.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET_N` in 1: reset, synchronous and active-low.
- `DREQ` in 4: hardware requests, level set by `dreq_pol`.
- `mask` in 4: mask register; 1 blocks the hardware request.
- `swreq` in 4: request register bits (software requests).
- `dreq_pol` in 1: command bit 6; 0 means DREQ is active-high, 1 means active-low.
- `dack_pol` in 1: command bit 7; 0 means DACK is active-low, 1 means active-high.
- `rot_pri` in 1: command bit 4; 0 selects fixed priority, 1 selects rotating priority.
- `ctrl_disable` in 1: command bit 2; 1 blocks new arbitration.
- `HLDA` in 1: hold acknowledge from the CPU.
- `eop` in 1: single-cycle pulse from the timing FSM marking service complete.
- `HRQ` out 1: hold request.
- `DACK` out 4: acknowledges, one-hot active.
- `grant_valid` out 1: a channel owns the bus.
- `grant_ch` out 2: serviced channel, `CHANNEL_SELECT_e`.

## Operation
**Request conditioning.** Each channel i has a valid request `vreq[i] = ((DREQ[i] ^ dreq_pol) & ~mask[i]) | swreq[i]`. Software requests ignore both mask and polarity.

**Priority.**
- Register `hp[1:0]` holds the highest-priority channel. Priority order is hp, hp+1, hp+2, hp+3, modulo 4.
- When `rot_pri=0`, `hp` is held at 0, so channel 0 is highest.
- When `rot_pri=1`, completing service of channel n sets `hp = n+1` (wraps 3 to 0).

**State machine.**
- `ARB_IDLE`: HRQ=0. If `|vreq` and `!ctrl_disable`, go to `ARB_HOLD`.
- `ARB_HOLD`: HRQ=1. The winner is re-resolved every cycle.
  - If `vreq` goes all-zero, return to `ARB_IDLE` (HRQ drops).
  - If HLDA=1, latch the winner into `grant_ch` and go to `ARB_GRANT`.
- `ARB_GRANT`: HRQ=1, `grant_valid=1`, `DACK[grant_ch]` active.
  - `eop=1`: go to `ARB_RELEASE` and update `hp` if rotating.
  - HLDA drops without `eop`: abort to `ARB_IDLE`; `hp` is unchanged.
- `ARB_RELEASE`: HRQ=0, no DACK active. Wait for HLDA=0, then go to `ARB_IDLE`.

**Boundary rules.**
- Masking or dropping the granted channel's request during `ARB_GRANT` has no effect until `eop`.
- `ctrl_disable` does not affect a grant already in progress.
- If `eop` and an HLDA drop occur in the same cycle, `eop` wins: go to `ARB_RELEASE` and rotate.
- `eop` outside `ARB_GRANT` is ignored.
- Ties cannot occur; the priority order is strict.

**Output encoding.**
- `DACK[i] = (grant_valid && grant_ch==i) ~^ dack_pol`, so inactive level is `~dack_pol`.
- `grant_ch` holds its last value when not granted.

## Timing
- **Reset** (`RESET_N=0` at an edge): state `ARB_IDLE`, HRQ=0, `grant_valid=0`, `grant_ch=0`, `hp=0`. DACK is at the inactive level from the following cycle.
- **Reset mid-grant:** the same values apply at the next edge with no `eop` processing.
- **Request to HRQ:** `vreq` sampled at edge k gives HRQ=1 in cycle k+1.
- **HLDA to grant:** HLDA sampled high at edge m gives `DACK` and `grant_valid` in cycle m+1.
- **Release:** `eop` at edge e gives DACK inactive, `grant_valid=0`, HRQ=0 in cycle e+1.
- **Turnaround:** the earliest next HRQ comes 2 cycles after HLDA is seen low in `ARB_RELEASE`.
- All outputs are registered except DACK. DACK is combinational only from registered grant state and `dack_pol`.

## Structure
- **DmaPackage additions:**
  - Arbiter state index enum (`iARB_IDLE` through `iARB_RELEASE`).
  - One-hot arbiter state enum, in the same style as the existing timing FSM.
  - `NUM_CH` constant.
  - Reuse `CHANNEL_SELECT_e` for `grant_ch`.
- **Sub-module `dma_rotating_prio_enc`:** combinational; inputs `vreq[3:0]` and `hp[1:0]`; outputs `win[1:0]` and `any`.

## Test plan
- **Fixed priority:** `rot_pri=0`, `dreq_pol=0`, DREQ=4'b1010, HLDA returned 1 cycle after HRQ → `grant_ch=1`; `DACK=4'b1101` with `dack_pol=0`.
- **Rotation:** `rot_pri=1`, all 4 DREQ held, 4 grant/`eop` rounds → grants in order 0,1,2,3; `hp` returns to 0.
- **Mask and software request:** `mask=4'b1111`, DREQ=4'b1111 → HRQ stays 0. Then `swreq=4'b0100` → `grant_ch=2`.
- **Withdrawal and abort:** drop all DREQ while in `ARB_HOLD` → HRQ=0 next cycle. HLDA drop mid-grant without `eop` → `ARB_IDLE`, `hp` unchanged.
- **Polarity:** `dreq_pol=1`, DREQ=4'b1110 → `grant_ch=0`. `dack_pol=1` → `DACK=4'b0001`.
- **Reset mid-grant:** `RESET_N=0` for 1 cycle during `ARB_GRANT` → HRQ=0, `grant_valid=0`, `hp=0` on the next cycle.
